// File: rtl/router_pkg.sv
// Shared router constants: byte width, FIFO depth and header field layout.
// Also holds the helper that turns a header byte into a packet byte count.
package router_pkg;

  localparam int DATA_W       = 8;
  localparam int FIFO_DEPTH   = 16;
  localparam int FIFO_ADDR_W  = $clog2(FIFO_DEPTH);
  localparam int LEN_MSB      = 7;
  localparam int LEN_LSB      = 2;
  localparam int PARITY_BYTES = 1;
  localparam int TAG_BIT      = DATA_W;
  localparam int CNT_W        = 7;

  // Payload length plus the trailing parity byte.
  function automatic logic [CNT_W-1:0] hdr_count(
    input logic [DATA_W-1:0] hdr
  );
    return CNT_W'(hdr[LEN_MSB:LEN_LSB]) + CNT_W'(PARITY_BYTES);
  endfunction

endpackage

// File: rtl/router_fifo_if.sv
// Write/read side bundle of one router output FIFO.
// master drives requests and data; slave is the FIFO.
interface router_fifo_if
  import router_pkg::*;
#(
  parameter int W = DATA_W
);

  logic             write_enb;
  logic             read_enb;
  logic             lfd_state;
  logic [W-1:0]     data_in;
  logic [W-1:0]     data_out;
  logic             empty;
  logic             full;
  logic [CNT_W-1:0] byte_count;

  modport master (
    output write_enb, read_enb, lfd_state, data_in,
    input  data_out, empty, full, byte_count
  );

  modport slave (
    input  write_enb, read_enb, lfd_state, data_in,
    output data_out, empty, full, byte_count
  );

endinterface

// File: rtl/router_fifo_mem.sv
// Dual-port storage array for the router FIFO.
// Synchronous write, combinational read; the top registers the output.
module router_fifo_mem #(
  parameter int W      = 9,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [W-1:0]      wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [W-1:0]      rdata
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we)
      mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/router_fifo.sv
// Per-port router output FIFO with header tagging.
// Tracks bytes left in the packet being drained on the read side.
module router_fifo
  import router_pkg::*;
#(
  parameter int DATA_W = router_pkg::DATA_W,
  parameter int DEPTH  = FIFO_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input logic         clock,
  input logic         resetn,
  input logic         soft_reset,
  router_fifo_if.slave bus
);

  localparam int PW = ADDR_W + 1;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [DATA_W:0]   rd_word;
  logic [DATA_W-1:0] data_q;
  logic [CNT_W-1:0]  count_q;
  logic              clr;
  logic              wr_ok;
  logic              rd_ok;

  assign clr = !resetn || soft_reset;

  assign bus.empty = (wr_ptr == rd_ptr);
  assign bus.full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);

  assign wr_ok = !clr && bus.write_enb && !bus.full;
  assign rd_ok = !clr && bus.read_enb && !bus.empty;

  assign bus.data_out   = data_q;
  assign bus.byte_count = count_q;

  router_fifo_mem #(
    .W      (DATA_W + 1),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clock (clock),
    .we    (wr_ok),
    .waddr (wr_ptr[ADDR_W-1:0]),
    .wdata ({bus.lfd_state, bus.data_in}),
    .raddr (rd_ptr[ADDR_W-1:0]),
    .rdata (rd_word)
  );

  always_ff @(posedge clock) begin
    if (clr) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      data_q  <= '0;
      count_q <= '0;
    end else begin
      if (wr_ok)
        wr_ptr <= wr_ptr + PW'(1);
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PW'(1);
        data_q <= rd_word[DATA_W-1:0];
        // A header restarts the count even if the old packet was cut short.
        if (rd_word[DATA_W])
          count_q <= hdr_count(rd_word[DATA_W-1:0]);
        else if (count_q != '0)
          count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_router_fifo.sv
// Scoreboard bench for router_fifo: directed plan plus random traffic.
// Expected reads come from a queue model of the FIFO and packet counter.
module tb_router_fifo;
  import router_pkg::*;

  logic clock;
  logic resetn;
  logic soft_reset;

  router_fifo_if bus ();

  router_fifo dut (
    .clock      (clock),
    .resetn     (resetn),
    .soft_reset (soft_reset),
    .bus        (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  logic [8:0]  m_q [$];
  logic [14:0] exp_q [$];
  int          m_bc = 0;
  logic [7:0]  m_dout = 8'h00;
  bit          fire = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clock)
    fire = bus.read_enb && !bus.empty && resetn && !soft_reset;

  always @(negedge clock) begin
    if (fire) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underrun: read seen with no expected entry at %0t", $time);
      end else begin
        logic [14:0] e;
        e = exp_q.pop_front();
        chk("sb_data", int'(bus.data_out), int'(e[14:7]));
        chk("sb_count", int'(bus.byte_count), int'(e[6:0]));
      end
    end
  end

  task automatic step(input bit rn, input bit sr, input bit we,
                      input bit re, input bit lfd, input logic [7:0] din);
    int sz;
    @(negedge clock);
    chk("empty", int'(bus.empty), int'(m_q.size() == 0));
    chk("full", int'(bus.full), int'(m_q.size() == FIFO_DEPTH));
    chk("data_out", int'(bus.data_out), int'(m_dout));
    chk("byte_count", int'(bus.byte_count), m_bc);
    resetn        = rn;
    soft_reset    = sr;
    bus.write_enb = we;
    bus.read_enb  = re;
    bus.lfd_state = lfd;
    bus.data_in   = din;
    if (!rn || sr) begin
      m_q.delete();
      m_bc   = 0;
      m_dout = 8'h00;
    end else begin
      sz = m_q.size();
      if (re && sz > 0) begin
        logic [8:0] e;
        e = m_q.pop_front();
        m_dout = e[7:0];
        if (e[8])
          m_bc = (int'(e[7:0]) / 4) + 1;
        else if (m_bc > 0)
          m_bc = m_bc - 1;
        exp_q.push_back({m_dout, 7'(m_bc)});
      end
      if (we && sz < FIFO_DEPTH)
        m_q.push_back({lfd, din});
    end
  endtask

  task automatic wr(input bit lfd, input logic [7:0] d);
    step(1, 0, 1, 0, lfd, d);
  endtask

  task automatic rd();
    step(1, 0, 0, 1, 0, 8'h00);
  endtask

  task automatic idle();
    step(1, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic hard_reset();
    step(0, 0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 0, 8'h00);
  endtask

  initial begin
    resetn        = 1'b0;
    soft_reset    = 1'b0;
    bus.write_enb = 1'b0;
    bus.read_enb  = 1'b0;
    bus.lfd_state = 1'b0;
    bus.data_in   = 8'h00;

    hard_reset();
    wr(1, 8'h14);
    idle();

    hard_reset();
    wr(1, 8'h14);
    for (int i = 0; i < 5; i++) wr(0, 8'hA0 + 8'(i));
    wr(0, 8'h55);
    for (int i = 0; i < 7; i++) rd();
    idle();
    rd();
    idle();

    for (int i = 0; i < 16; i++) wr(0, 8'(8'h30 + i));
    wr(0, 8'hFF);
    step(1, 0, 1, 1, 0, 8'hFE);
    for (int i = 0; i < 16; i++) rd();
    idle();

    hard_reset();
    for (int i = 0; i < 10; i++) wr(0, 8'(i));
    for (int i = 0; i < 10; i++) rd();
    for (int i = 0; i < 15; i++) wr(0, 8'(8'h40 + i));
    for (int i = 0; i < 12; i++) step(1, 0, 1, 1, 0, 8'(8'h60 + i));
    for (int i = 0; i < 15; i++) rd();
    idle();

    wr(1, 8'h14);
    for (int i = 0; i < 5; i++) wr(0, 8'(8'hB0 + i));
    for (int i = 0; i < 3; i++) rd();
    step(1, 1, 1, 0, 1, 8'h77);
    idle();
    rd();
    idle();

    wr(1, 8'h00);
    wr(0, 8'h11);
    wr(0, 8'h22);
    rd();
    rd();
    rd();
    idle();

    wr(1, 8'h10);
    wr(0, 8'h01);
    wr(1, 8'h08);
    wr(0, 8'h02);
    for (int i = 0; i < 4; i++) rd();
    idle();

    for (int i = 0; i < 3000; i++) begin
      bit wbias;
      int wp;
      bit rn;
      bit sr;
      wbias = ((i / 150) % 2) == 0;
      wp = wbias ? 75 : 30;
      rn = $urandom_range(0, 299) != 0;
      sr = $urandom_range(0, 199) == 0;
      step(rn, sr,
           $urandom_range(0, 99) < wp,
           $urandom_range(0, 99) < (100 - wp),
           $urandom_range(0, 3) == 0,
           8'($urandom));
    end

    idle();
    idle();
    idle();
    chk("sb_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
